// File: rtl/icache_refill_responder.sv
// Icache refill port memory responder: answers Get requests with address-derived AccessAckData bursts.
// Optional ICACHE_RESP_STALL_EN inserts a one-cycle d_valid bubble every fourth BURST cycle.
module icache_refill_responder #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int SRC_W    = 2,
  parameter int LATENCY  = 3,
  parameter int MAX_SIZE = 6
) (
  input  logic              icache_clock_gate_out,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [3:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [3:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_denied,
  output logic [DATA_W-1:0] d_data
);

  // state    | meaning
  // ST_IDLE  | a_ready high, waiting for a request
  // ST_WAIT  | latency countdown after accept
  // ST_BURST | presenting response beats on channel D

  localparam int         BEAT_BYTES  = DATA_W / 8;
  localparam int         LG_BB       = $clog2(BEAT_BYTES);
  localparam int         BEAT_W      = 16;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;

  state_t              state, state_nxt;
  logic [7:0]          wait_cnt;
  logic [BEAT_W-1:0]   beat_idx, beat_last;
  logic [3:0]          cap_size;
  logic [SRC_W-1:0]    cap_source;
  logic [ADDR_W-1:0]   cap_base;
  logic                cap_err;
  logic                accept, beat_fire, last_fire, bubble;
  logic                req_err;
  logic [ADDR_W-1:0]   req_base, beat_addr;
  logic [BEAT_W-1:0]   req_last;

  assign a_ready   = (state == ST_IDLE);
  assign accept    = a_valid & a_ready;
  assign beat_fire = d_valid & d_ready;
  assign last_fire = beat_fire && (beat_idx == beat_last);

  always_comb begin
    req_err  = (a_opcode != OP_GET) || (a_size > 4'(MAX_SIZE));
    req_base = a_address & ~((ADDR_W'(1) << a_size) - ADDR_W'(1));
    req_last = '0;
    // Error responses are always a single beat regardless of a_size.
    if (!req_err && (a_size > 4'(LG_BB)))
      req_last = (BEAT_W'(1) << (a_size - 4'(LG_BB))) - BEAT_W'(1);
  end

`ifdef ICACHE_RESP_STALL_EN
  logic [1:0] stall_cnt;

  always_ff @(posedge icache_clock_gate_out) begin
    if (reset)
      stall_cnt <= '0;
    else if (state == ST_BURST)
      stall_cnt <= stall_cnt + 2'd1;
  end

  assign bubble = (stall_cnt == 2'd3);
`else
  assign bubble = 1'b0;
`endif

  always_ff @(posedge icache_clock_gate_out) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept)           state_nxt = ST_WAIT;
      ST_WAIT:  if (wait_cnt == '0)   state_nxt = ST_BURST;
      ST_BURST: if (last_fire)        state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge icache_clock_gate_out) begin
    if (reset) begin
      wait_cnt   <= '0;
      beat_idx   <= '0;
      beat_last  <= '0;
      cap_size   <= '0;
      cap_source <= '0;
      cap_base   <= '0;
      cap_err    <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt   <= 8'(LATENCY - 1);
        beat_idx   <= '0;
        beat_last  <= req_last;
        cap_size   <= a_size;
        cap_source <= a_source;
        cap_base   <= req_base;
        cap_err    <= req_err;
      end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
      if (beat_fire && !last_fire)
        beat_idx <= beat_idx + BEAT_W'(1);
    end
  end

  assign beat_addr = cap_base + (ADDR_W'(beat_idx) << LG_BB);

  assign d_valid  = (state == ST_BURST) && !bubble;
  assign d_opcode = OP_ACK_DATA;
  assign d_size   = cap_size;
  assign d_source = cap_source;
  assign d_denied = cap_err && (state == ST_BURST);
  assign d_data   = cap_err ? '0 : DATA_W'(beat_addr);

endmodule

// File: tb/tb_icache_refill_responder.sv
// Self-checking bench for icache_refill_responder: directed and random Get/error transactions
// checked beat by beat against a reference model of the refill response rules.
module tb_icache_refill_responder;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 64;
  localparam int SRC_W    = 2;
  localparam int LATENCY  = 3;
  localparam int MAX_SIZE = 6;
`ifdef ICACHE_RESP_STALL_EN
  localparam bit STALL_BUILD = 1'b1;
`else
  localparam bit STALL_BUILD = 1'b0;
`endif

  logic              icache_clock_gate_out = 1'b0;
  logic              reset = 1'b1;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [2:0]        a_opcode = 3'd0;
  logic [3:0]        a_size = 4'd0;
  logic [SRC_W-1:0]  a_source = '0;
  logic [ADDR_W-1:0] a_address = '0;
  logic              d_valid;
  logic              d_ready = 1'b0;
  logic [2:0]        d_opcode;
  logic [3:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic [DATA_W-1:0] d_data;

  int checks = 0;
  int failures = 0;
  int phase = 0;

  always #5 icache_clock_gate_out = ~icache_clock_gate_out;

  icache_refill_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .LATENCY(LATENCY), .MAX_SIZE(MAX_SIZE)
  ) dut (
    .icache_clock_gate_out(icache_clock_gate_out),
    .reset(reset),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_opcode(a_opcode),
    .a_size(a_size),
    .a_source(a_source),
    .a_address(a_address),
    .d_valid(d_valid),
    .d_ready(d_ready),
    .d_opcode(d_opcode),
    .d_size(d_size),
    .d_source(d_source),
    .d_denied(d_denied),
    .d_data(d_data)
  );

  // Issues one request and follows it to completion; gap is the earliest next-accept distance
  // in cycles, or -1 when the burst was aborted by reset during beat abort_at.
  task automatic run_txn(input string name, input logic [2:0] op, input logic [3:0] sz,
                         input logic [SRC_W-1:0] src, input logic [ADDR_W-1:0] addr,
                         input int ready_mode, input bit hold_junk, input int abort_at,
                         output int gap);
    bit                err, exp_v, rdy;
    int                beats, idx, cyc, n;
    longint            base, line;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    err   = (op != 3'd4) || (int'(sz) > MAX_SIZE);
    beats = (err || sz <= 4'd3) ? 1 : (1 << sz) / (DATA_W / 8);
    line  = longint'(1) << sz;
    base  = longint'(addr) - (longint'(addr) % line);
    gap   = 0;
    @(negedge icache_clock_gate_out);
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src; a_address = addr;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: a_ready=%b want 1", name, a_ready);
    end
    for (int k = 0; k < LATENCY; k++) begin
      @(negedge icache_clock_gate_out);
      if (hold_junk) begin
        a_opcode = 3'($urandom); a_size = 4'($urandom); a_source = SRC_W'($urandom);
        a_address = $urandom;
      end else begin
        a_valid = 1'b0;
      end
      checks++;
      if (d_valid !== 1'b0 || a_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s wait%0d: d_valid=%b a_ready=%b want 0 0", name, k, d_valid, a_ready);
      end
    end
    n = LATENCY - 1;
    idx = 0;
    cyc = 0;
    while (idx < beats) begin
      @(negedge icache_clock_gate_out);
      n++;
      if (cyc > 200) begin
        failures++;
        $display("FAIL %s timeout: beats seen=%0d want %0d", name, idx, beats);
        break;
      end
      exp_v = !(STALL_BUILD && phase == 3);
      checks++;
      if (d_valid !== exp_v || a_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s cycle%0d: d_valid=%b a_ready=%b want %b 0", name, cyc, d_valid, a_ready, exp_v);
      end
      if (exp_v) begin
        exp_addr = ADDR_W'(base + longint'(idx) * (DATA_W / 8));
        exp_data = err ? '0 : DATA_W'(exp_addr);
        checks++;
        if ({d_opcode, d_size, d_source, d_denied, d_data} !== {3'd1, sz, src, err, exp_data}) begin
          failures++;
          $display("FAIL %s beat%0d: op=%0d size=%0d src=%0d denied=%b data=%h want op=1 size=%0d src=%0d denied=%b data=%h",
                   name, idx, d_opcode, d_size, d_source, d_denied, d_data, sz, src, err, exp_data);
        end
      end
      if (idx == abort_at) begin
        reset = 1'b1; d_ready = 1'b0; a_valid = 1'b0;
        @(negedge icache_clock_gate_out);
        reset = 1'b0;
        phase = 0;
        gap = -1;
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (d_valid !== 1'b0 || a_ready !== 1'b1 || d_denied !== 1'b0 || d_data !== '0
              || d_size !== 4'd0 || d_source !== '0) begin
            failures++;
            $display("FAIL %s post_reset%0d: d_valid=%b a_ready=%b denied=%b data=%h size=%0d src=%0d want 0 1 0 0 0 0",
                     name, k, d_valid, a_ready, d_denied, d_data, d_size, d_source);
          end
          @(negedge icache_clock_gate_out);
        end
        return;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      d_ready = rdy;
      if (exp_v && rdy) idx++;
      phase = (phase + 1) % 4;
      cyc++;
    end
    @(negedge icache_clock_gate_out);
    n++;
    a_valid = 1'b0;
    d_ready = 1'b0;
    checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s done: a_ready=%b d_valid=%b want 1 0", name, a_ready, d_valid);
    end
    gap = n + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge icache_clock_gate_out);
    reset = 1'b0;
    @(negedge icache_clock_gate_out);
    checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0 || d_denied !== 1'b0 || d_data !== '0
        || d_size !== 4'd0 || d_source !== '0) begin
      failures++;
      $display("FAIL reset: a_ready=%b d_valid=%b denied=%b data=%h size=%0d src=%0d want 1 0 0 0 0 0",
               a_ready, d_valid, d_denied, d_data, d_size, d_source);
    end
  endtask

  task automatic test_full_line();
    int gap;
    run_txn("full_line", 3'd4, 4'd6, 2'd2, 32'h8000_1234, 0, 1'b0, -1, gap);
    if (!STALL_BUILD) begin
      checks++;
      if (gap !== 12) begin
        failures++;
        $display("FAIL full_line gap: got %0d want 12", gap);
      end
    end
  endtask

  task automatic test_single_beat();
    int gap;
    run_txn("single_beat", 3'd4, 4'd2, 2'd1, 32'h0000_0010, 0, 1'b0, -1, gap);
    if (!STALL_BUILD) begin
      checks++;
      if (gap !== 5) begin
        failures++;
        $display("FAIL single_beat gap: got %0d want 5", gap);
      end
    end
  endtask

  task automatic test_error();
    int gap;
    run_txn("err_put", 3'd0, 4'd6, 2'd3, 32'h1234_5678, 0, 1'b0, -1, gap);
    run_txn("err_size7", 3'd4, 4'd7, 2'd1, 32'h0000_0400, 0, 1'b0, -1, gap);
    if (!STALL_BUILD) begin
      checks++;
      if (gap !== LATENCY + 2) begin
        failures++;
        $display("FAIL err_size7 gap: got %0d want %0d", gap, LATENCY + 2);
      end
    end
  endtask

  task automatic test_backpressure();
    int gap;
    run_txn("backpressure", 3'd4, 4'd6, 2'd0, 32'h0000_2040, 1, 1'b0, -1, gap);
    run_txn("busy_junk", 3'd4, 4'd5, 2'd3, 32'h0000_7777, 2, 1'b1, -1, gap);
  endtask

  task automatic test_reset_mid_burst();
    int gap;
    run_txn("abort", 3'd4, 4'd6, 2'd1, 32'h0000_3000, 0, 1'b0, 3, gap);
    run_txn("after_abort", 3'd4, 4'd6, 2'd2, 32'h0000_3100, 0, 1'b0, -1, gap);
  endtask

  task automatic test_wrap_stall();
    int gap;
    run_txn("top_line", 3'd4, 4'd6, 2'd3, 32'hFFFF_FFC0, 0, 1'b0, -1, gap);
    run_txn("top_line_bp", 3'd4, 4'd6, 2'd0, 32'hFFFF_FFE8, 2, 1'b0, -1, gap);
  endtask

  task automatic test_random();
    int gap;
    logic [2:0] op;
    for (int t = 0; t < 14; t++) begin
      op = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd4;
      run_txn("random", op, 4'($urandom_range(0, 8)), SRC_W'($urandom), $urandom,
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1, gap);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_line();
    test_single_beat();
    test_error();
    test_backpressure();
    test_reset_mid_burst();
    test_wrap_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
